// File: rtl/wqi_class_qualifier.sv
// Water-quality class qualifier: maps fuzzy set IDs to classes and commits a class
// only after PERSIST consecutive agreeing samples. Optional sticky alarm: WQI_ALARM_EN.
module wqi_class_qualifier #(
  parameter int unsigned PERSIST = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  input  logic [7:0]  SET_ID,
  input  logic [7:0]  WQI_FUZZY,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [2:0]  OUT_CLASS,
  output logic [7:0]  OUT_STRENGTH,
  output logic        ID_ERR,
  output logic [15:0] EVENT_CNT,
  output logic        ALARM,
  input  logic        ALARM_CLR
);

  localparam logic [7:0] PersistC = 8'(PERSIST);

  typedef enum logic [1:0] {IDLE, TRACK, PEND} stateT;

  stateT      state;
  logic [2:0] candClass;
  logic [7:0] candCnt;
  logic [7:0] candStr;
  logic [2:0] commClass;
  logic       idLegal;
  logic [2:0] sampleClass;

  assign idLegal = (SET_ID != 8'd0) && (SET_ID < 8'd8);

  always_comb begin
    sampleClass = '0;
    case (SET_ID)
      8'd1:       sampleClass = 3'd7;
      8'd2, 8'd3: sampleClass = 3'd1;
      8'd4:       sampleClass = 3'd2;
      8'd5:       sampleClass = 3'd3;
      8'd6:       sampleClass = 3'd4;
      8'd7:       sampleClass = 3'd5;
      default:    sampleClass = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      candClass    <= '0;
      candCnt      <= '0;
      candStr      <= '0;
      commClass    <= '0;
      OUT_VALID    <= 1'b0;
      OUT_CLASS    <= '0;
      OUT_STRENGTH <= '0;
      ID_ERR       <= 1'b0;
      EVENT_CNT    <= '0;
    end else begin
      ID_ERR <= IN_VALID && !idLegal;
      if (IN_VALID) begin
        if (!idLegal) begin
          candCnt <= '0;
        end else if (state != IDLE && sampleClass == commClass) begin
          candCnt <= '0;
        end else if (sampleClass == candClass && candCnt != '0) begin
          candCnt <= (candCnt >= PersistC) ? PersistC : candCnt + 8'd1;
          candStr <= WQI_FUZZY;
        end else begin
          candClass <= sampleClass;
          candCnt   <= 8'd1;
          candStr   <= WQI_FUZZY;
        end
      end
      // Commit uses the registered candidate and its later candCnt write overrides the sample path.
      case (state)
        IDLE, TRACK: begin
          if (candCnt == PersistC) begin
            commClass    <= candClass;
            OUT_CLASS    <= candClass;
            OUT_STRENGTH <= candStr;
            OUT_VALID    <= 1'b1;
            candCnt      <= '0;
            state        <= PEND;
          end
        end
        PEND: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            EVENT_CNT <= EVENT_CNT + 16'd1;
            state     <= TRACK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WQI_ALARM_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ALARM <= 1'b0;
    end else if (state == PEND && OUT_READY && OUT_CLASS >= 3'd4) begin
      ALARM <= 1'b1;
    end else if (ALARM_CLR) begin
      ALARM <= 1'b0;
    end
  end
`else
  logic unusedAlarmClr;
  assign unusedAlarmClr = ALARM_CLR;
  assign ALARM = 1'b0;
`endif

endmodule

// File: tb/tb_wqi_class_qualifier.sv
// Directed plus random bench for wqi_class_qualifier against a cycle-level reference model.
module tb_wqi_class_qualifier;
  localparam int P = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IN_VALID;
  logic [7:0]  SET_ID;
  logic [7:0]  WQI_FUZZY;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [2:0]  OUT_CLASS;
  logic [7:0]  OUT_STRENGTH;
  logic        ID_ERR;
  logic [15:0] EVENT_CNT;
  logic        ALARM;
  logic        ALARM_CLR;

  int errors = 0;
  int checks = 0;

  wqi_class_qualifier #(.PERSIST(P)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .SET_ID(SET_ID),
    .WQI_FUZZY(WQI_FUZZY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_CLASS(OUT_CLASS), .OUT_STRENGTH(OUT_STRENGTH), .ID_ERR(ID_ERR),
    .EVENT_CNT(EVENT_CNT), .ALARM(ALARM), .ALARM_CLR(ALARM_CLR)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  int clsTab [0:7] = '{0, 7, 1, 1, 2, 3, 4, 5};
  int mCandClass, mCandCnt, mCandStr, mCommClass;
  bit mCommVld, mOutValid, mIdErr, mAlarm;
  int mOutClass, mOutStr, mEvCnt;

  function automatic void modelReset();
    mCandClass = 0; mCandCnt = 0; mCandStr = 0; mCommClass = 0; mCommVld = 0;
    mOutValid = 0; mOutClass = 0; mOutStr = 0; mIdErr = 0; mEvCnt = 0; mAlarm = 0;
  endfunction

  function automatic void modelEdge(bit iv, int id, int fz, bit rdy, bit clr);
    bit commit = (mCandCnt == P) && !mOutValid;
    bit accept = mOutValid && rdy;
    int oldClass = mCandClass;
    int oldStr = mCandStr;
    int c;
    bit legal = (id >= 1 && id <= 7);
    mIdErr = iv && !legal;
    if (iv && !legal) mCandCnt = 0;
    else if (iv) begin
      c = clsTab[id];
      if (mCommVld && c == mCommClass) mCandCnt = 0;
      else if (c == mCandClass && mCandCnt != 0) begin
        mCandCnt = (mCandCnt + 1 > P) ? P : mCandCnt + 1;
        mCandStr = fz;
      end else begin
        mCandClass = c; mCandCnt = 1; mCandStr = fz;
      end
    end
`ifdef WQI_ALARM_EN
    if (accept && mOutClass >= 4) mAlarm = 1;
    else if (clr) mAlarm = 0;
`endif
    if (accept) begin
      mEvCnt = (mEvCnt + 1) % 65536;
      mOutValid = 0;
    end
    if (commit) begin
      mCommClass = oldClass; mCommVld = 1;
      mOutClass = oldClass; mOutStr = oldStr; mOutValid = 1; mCandCnt = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit iv = IN_VALID;
    int id = int'(SET_ID);
    int fz = int'(WQI_FUZZY);
    bit rdy = OUT_READY;
    bit clr = ALARM_CLR;
    @(posedge CLK);
    if (RST_N) modelEdge(iv, id, fz, rdy, clr);
    else modelReset();
    #1;
    chk("out_valid", 32'(OUT_VALID), 32'(mOutValid));
    chk("out_class", 32'(OUT_CLASS), 32'(mOutClass));
    chk("out_strength", 32'(OUT_STRENGTH), 32'(mOutStr));
    chk("id_err", 32'(ID_ERR), 32'(mIdErr));
    chk("event_cnt", 32'(EVENT_CNT), 32'(mEvCnt));
    chk("alarm", 32'(ALARM), 32'(mAlarm));
  endtask

  task automatic smp(input int id, input int fz);
    IN_VALID = 1'b1; SET_ID = 8'(id); WQI_FUZZY = 8'(fz);
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic doReset();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
  endtask

  initial begin
    int lastId;
    int pool [7] = '{5, 5, 4, 5, 5, 5, 5};
    modelReset();
    RST_N = 1'b0; IN_VALID = 1'b0; SET_ID = '0; WQI_FUZZY = '0;
    OUT_READY = 1'b0; ALARM_CLR = 1'b0;
    idle(2);
    chk("rst_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_evcnt", 32'(EVENT_CNT), 32'd0);
    RST_N = 1'b1;

    // Four SET_ID=4 samples, event after the following edge
    for (int i = 0; i < 4; i++) smp(4, 1);
    chk("lat_not_yet", 32'(OUT_VALID), 32'd0);
    idle(1);
    chk("t1_valid", 32'(OUT_VALID), 32'd1);
    chk("t1_class", 32'(OUT_CLASS), 32'd2);
    chk("t1_str", 32'(OUT_STRENGTH), 32'd1);
    OUT_READY = 1'b1; idle(1); OUT_READY = 1'b0;
    chk("t1_evcnt", 32'(EVENT_CNT), 32'd1);

    // 5,5,4,5,5,5,5 with class 2 committed
    for (int i = 0; i < 7; i++) begin
      smp(pool[i], 16 + i);
      chk("t2_no_evt", 32'(OUT_VALID), 32'd0);
    end
    idle(1);
    chk("t2_class", 32'(OUT_CLASS), 32'd3);
    chk("t2_str", 32'(OUT_STRENGTH), 32'd22);
    OUT_READY = 1'b1; idle(1); OUT_READY = 1'b0;

    // Alternating 2/3 maps to one class: exactly one event
    doReset();
    OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) smp((i % 2 == 0) ? 2 : 3, 40 + i);
    idle(2);
    OUT_READY = 1'b0;
    chk("t3_evcnt", 32'(EVENT_CNT), 32'd1);
    chk("t3_valid", 32'(OUT_VALID), 32'd0);

    // Illegal ID breaks the streak
    for (int i = 0; i < 3; i++) smp(6, 60);
    smp(0, 0);
    chk("t4_iderr", 32'(ID_ERR), 32'd1);
    idle(1);
    chk("t4_iderr_off", 32'(ID_ERR), 32'd0);
    chk("t4_no_evt", 32'(OUT_VALID), 32'd0);
    for (int i = 0; i < 4; i++) smp(6, 70 + i);
    idle(1);
    chk("t4_class", 32'(OUT_CLASS), 32'd4);

    // Stall in PEND while a new class qualifies
    for (int i = 0; i < 4; i++) smp(7, 80 + i);
    idle(6);
    chk("t5_held", 32'(OUT_CLASS), 32'd4);
    OUT_READY = 1'b1; idle(1); OUT_READY = 1'b0;
    chk("t5_gap", 32'(OUT_VALID), 32'd0);
    idle(1);
    chk("t5_valid", 32'(OUT_VALID), 32'd1);
    chk("t5_class", 32'(OUT_CLASS), 32'd5);
    chk("t5_str", 32'(OUT_STRENGTH), 32'd83);
    OUT_READY = 1'b1; idle(1); OUT_READY = 1'b0;
`ifdef WQI_ALARM_EN
    chk("alarm_set", 32'(ALARM), 32'd1);
`else
    chk("alarm_off", 32'(ALARM), 32'd0);
`endif
    ALARM_CLR = 1'b1; idle(1); ALARM_CLR = 1'b0;
    chk("alarm_clr", 32'(ALARM), 32'd0);

    // Reset during PEND discards the event immediately
    for (int i = 0; i < 4; i++) smp(2, 90);
    idle(1);
    chk("pend_before_rst", 32'(OUT_VALID), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("async_rst_valid", 32'(OUT_VALID), 32'd0);
    chk("async_rst_evcnt", 32'(EVENT_CNT), 32'd0);
    modelReset();
    idle(1);
    RST_N = 1'b1;

    // Random traffic against the model
    lastId = 4;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        lastId = ($urandom_range(0, 15) == 0) ? int'($urandom_range(8, 255)) : int'($urandom_range(0, 7));
      end
      IN_VALID  = ($urandom_range(0, 3) != 0);
      SET_ID    = 8'(lastId);
      WQI_FUZZY = 8'($urandom_range(0, 255));
      OUT_READY = ($urandom_range(0, 2) == 0);
      ALARM_CLR = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wqi_class_qualifier.md
# wqi_class_qualifier

Downstream consumer of the fuzzification stage: samples the selected fuzzy set ID and its membership byte, maps the set ID to a water-quality class, and requires a run of consecutive agreeing samples before committing a class change. Each committed change is presented on a valid/ready output port to the reporting/display stage. It suppresses chatter when the crisp WQI sits near a set boundary.

## Interface
- PERSIST, 4: consecutive legal matching samples required to commit a class; legal range 1..255.
- CLK  input  1  sole clock, all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  qualifies SET_ID/WQI_FUZZY this cycle.
- SET_ID  input  8  fuzzy set ID from fuzzification (legal 1..7).
- WQI_FUZZY  input  8  membership value accompanying SET_ID.
- OUT_VALID  output  1  committed-class event pending.
- OUT_READY  input  1  consumer accepts event when high with OUT_VALID.
- OUT_CLASS  output  3  committed class code.
- OUT_STRENGTH  output  8  WQI_FUZZY of the sample that completed qualification.
- ID_ERR  output  1  one-cycle pulse on an illegal SET_ID.
- EVENT_CNT  output  16  number of accepted events, wraps 0xFFFF→0.
- ALARM  output  1  sticky alarm (see Configuration).
- ALARM_CLR  input  1  clears ALARM.

## Operation
- Class map: ID1→7 (FAULT, negative WQI), ID2→1, ID3→1 (EXCELLENT), ID4→2 (GOOD), ID5→3 (POOR), ID6→4 (VERY_POOR), ID7→5 (UNSUITABLE). IDs 0 and 8..255 illegal.
- Internal: cand_class[2:0], cand_cnt[7:0], cand_str[7:0], comm_class[2:0], comm_vld.
- IN_VALID=0: no state change; streak preserved.
- Illegal ID with IN_VALID=1: cand_cnt←0, ID_ERR=1 next cycle only.
- Legal sample, class c: if comm_vld and c==comm_class → cand_cnt←0. Else if c==cand_class and cand_cnt≠0 → cand_cnt←min(cand_cnt+1, PERSIST), cand_str←WQI_FUZZY. Else cand_class←c, cand_cnt←1, cand_str←WQI_FUZZY.
- Commit: when registered cand_cnt==PERSIST and OUT_VALID=0 → comm_class←cand_class, comm_vld←1, OUT_CLASS←cand_class, OUT_STRENGTH←cand_str, OUT_VALID←1, cand_cnt←0. A legal sample arriving in the commit cycle is evaluated against the old comm_class, then the commit clears cand_cnt (commit wins).
- States: IDLE (comm_vld=0), TRACK (comm_vld=1, OUT_VALID=0), PEND (OUT_VALID=1). IDLE→PEND and TRACK→PEND on commit; PEND→TRACK on edge sampling OUT_READY=1; no other transitions except reset.
- In PEND, qualification continues; cand_cnt saturates at PERSIST; OUT_CLASS/OUT_STRENGTH held stable.
- Handshake: event transferred on edge with OUT_VALID=1 and OUT_READY=1; EVENT_CNT increments same edge.

## Timing
- Reset (async assert, sync release): OUT_VALID=0, OUT_CLASS=0, OUT_STRENGTH=0, ID_ERR=0, EVENT_CNT=0, ALARM=0, all internal state 0, state IDLE.
- Latency: PERSIST-th matching sample at edge k → OUT_VALID high after edge k+1.
- Back-to-back events: OUT_VALID low for at least one cycle between events (commit only when OUT_VALID=0 registered).
- OUT_READY high with OUT_VALID low: ignored.
- PERSIST=1: every legal non-committed class commits one cycle after its sample.
- Reset asserted during PEND: event discarded, outputs to reset values immediately.

## Configuration
- WQI_ALARM_EN defined: ALARM set on the edge an event with OUT_CLASS ≥4 (VERY_POOR, UNSUITABLE, FAULT) is accepted; held until ALARM_CLR sampled high; simultaneous set and clear → set wins.
- Undefined: ALARM tied 0, ALARM_CLR ignored; all other behaviour identical.

## Test plan
- PERSIST=4, reset, four valid SET_ID=4 (WQI_FUZZY=1) → OUT_VALID high after 5th edge, OUT_CLASS=2, OUT_STRENGTH=1; READY=1 → EVENT_CNT=1.
- Committed class 2, samples 5,5,4,5,5,5,5 → single event OUT_CLASS=3 only after final four 5s; no event from the 4.
- SET_ID=2 then 3 alternating ×8 after reset → one event OUT_CLASS=1 (same class), no further events.
- Streak of three 6s, SET_ID=0 → ID_ERR one-cycle pulse, cand_cnt=0; then four 6s → OUT_CLASS=4.
- OUT_READY=0 for 10 cycles during PEND while input changes to 7 ×4 → OUT_CLASS held 4; after READY, OUT_VALID low one cycle, then OUT_CLASS=5.
- WQI_ALARM_EN: accept OUT_CLASS=5 → ALARM=1; ALARM_CLR pulse → ALARM=0; without macro ALARM stays 0.
